cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Parametrised multicycle state sequencer for the bus-based MIPS core: owns the state register that the control unit decodes (HALT/FETCH/DECODE/EXEC1/EXEC2) and advances it once per instruction phase. It adds what the bare state encoding lacks:
- Avalon `waitrequest` stall handling
- a multiply/divide wait state
- a bus-stall watchdog with sticky timeout
- halt-on-request
- a retired-instruction counter

It sits between the Avalon master port, the control unit and the mult/div unit.

## Interface
Parameters:
- `MD_ENABLE`, 1: 1 inserts MDWAIT after EXEC1 for mult/div functions; 0 never enters MDWAIT.
- `MAX_STALL`, 255: consecutive bus-stall cycles that trigger timeout; legal range 1..65535.
- `COUNT_W`, 32: width of `instr_count`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `opcode` in 6: instruction register bits 31:26.
- `fun` in 6: instruction register bits 5:0.
- `bus_req` in 1: control unit memread|memwrite for the current state.
- `waitrequest` in 1: Avalon waitrequest.
- `md_busy` in 1: mult/div unit still computing.
- `halt_req` in 1: PC target is 0; sampled in EXEC2.
- `state` out 4: 0 HALT, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2, 5 MDWAIT.
- `active` out 1: state != HALT.
- `stalled` out 1: bus_req & waitrequest, or state==MDWAIT & md_busy.
- `bus_timeout` out 1: sticky watchdog flag.
- `instr_count` out COUNT_W: retired instructions.

## Operation
- `md_op` = opcode==0 & fun in {011000, 011001, 011010, 011011}.
- `bstall` = bus_req & waitrequest.
- HALT: sticky; exits only via reset.
- FETCH: bstall → FETCH; else → DECODE.
- DECODE: → EXEC1 unconditionally (no bus access in DECODE).
- EXEC1 checks, in priority order:
  - bstall → EXEC1.
  - MD_ENABLE & md_op → MDWAIT.
  - otherwise → EXEC2.
- MDWAIT: md_busy → MDWAIT; else → EXEC2. MDWAIT is entered for at least 1 cycle even if md_busy is already low.
- EXEC2 checks, in priority order:
  - bstall → EXEC2.
  - halt_req → HALT.
  - otherwise → FETCH.
- Retire: leaving EXEC2 (to FETCH or HALT) increments `instr_count` by 1 and wraps modulo 2^COUNT_W.
- Watchdog:
  - `stall_cnt` (width clog2(MAX_STALL+1)) increments each cycle bstall is high in FETCH/EXEC1/EXEC2.
  - It clears on any cycle bstall is low. It never counts in MDWAIT, DECODE or HALT.
  - When `stall_cnt` == MAX_STALL-1 and bstall is still high: next state = HALT, `bus_timeout` ← 1 (sticky until reset), `stall_cnt` ← 0.
  - No retire counts on a timeout exit.
- Priority on simultaneous events: watchdog timeout > bstall hold > halt_req/md_op transitions.
- Undefined `state` codes 6..15 → HALT on the next edge.

## Timing
- Reset (async assert, any cycle including mid-stall or MDWAIT):
  - state=1 (FETCH), active=1, stalled follows inputs combinationally.
  - bus_timeout=0, instr_count=0, stall_cnt=0.
- Reset release: first rising edge evaluates FETCH normally.
- All state/counter updates on the rising edge; `active`, `stalled` and `state` are registered or derived from registered state, except `stalled`, which is combinational from inputs.
- Minimum instruction latency: 4 cycles (FETCH, DECODE, EXEC1, EXEC2) with waitrequest low.
- Each waitrequest-high cycle during a bus_req state adds exactly 1 cycle.
- Mult/div instruction: 5 + N cycles, where N = cycles md_busy stays high after MDWAIT entry (N ≥ 0).
- The control unit's pcwrite (exec2 & !waitrequest) coincides with the EXEC2 exit edge; the sequencer must not leave EXEC2 on any other cycle.
- Timeout: HALT is reached on the edge that completes MAX_STALL consecutive stalled cycles.

## Test plan
- Reset, then 3 ADDIU instructions (opcode 001001), waitrequest=0, halt_req on the 3rd:
  - state sequence 1,2,3,4 repeating.
  - HALT at cycle 12.
  - instr_count=3, active=0.
- LW (100011) with waitrequest high for 2 cycles in FETCH and 3 in EXEC1: FETCH lasts 3 cycles, EXEC1 lasts 4, total 9 cycles; instr_count +1.
- MULT (opcode 0, fun 011000) with md_busy high 5 cycles after MDWAIT entry:
  - MDWAIT lasts 6 cycles, instruction takes 10 cycles.
  - With MD_ENABLE=0 it takes 4 cycles.
- MAX_STALL=4, waitrequest stuck high in FETCH:
  - HALT after 4 cycles, bus_timeout=1, instr_count unchanged.
  - Stall of 3 cycles, then low, then 3 more: no timeout.
- Assert reset mid-MDWAIT and mid-EXEC2 stall: state=1 immediately (async), bus_timeout=0, instr_count=0; normal fetch resumes after release.
- COUNT_W=4, 17 retirements: instr_count wraps 15→0 and reads 1.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle state sequencer for the bus-based MIPS core.
// It holds the state register that the control unit decodes, stalls on Avalon
// waitrequest, inserts a mult/div wait state, runs a bus-stall watchdog with a
// sticky timeout, halts on request and counts retired instructions.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (forces FETCH)
//   opcode/fun   instruction register fields [31:26] / [5:0]
//   bus_req      control unit memread|memwrite for the current state
//   waitrequest  Avalon waitrequest
//   md_busy      mult/div unit still computing
//   halt_req     PC target is 0, sampled in EXEC2
//   state        0 HALT, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2, 5 MDWAIT
//   active       state != HALT
//   stalled      combinational stall indication
//   bus_timeout  sticky watchdog flag
//   instr_count  retired-instruction counter (wraps)
module cpu_sequencer #(
  parameter int unsigned MD_ENABLE = 1,
  parameter int unsigned MAX_STALL = 255,
  parameter int unsigned COUNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         fun,
  input  logic               bus_req,
  input  logic               waitrequest,
  input  logic               md_busy,
  input  logic               halt_req,
  output logic [3:0]         state,
  output logic               active,
  output logic               stalled,
  output logic               bus_timeout,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);
  localparam bit          MD_EN   = (MD_ENABLE != 0);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MAX_STALL - 1);

  typedef enum logic [3:0] {
    ST_HALT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC1  = 4'd3,
    ST_EXEC2  = 4'd4,
    ST_MDWAIT = 4'd5
  } state_e;

  state_e               state_q, state_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic md_op;
  logic bstall;
  logic watch;
  logic wd_fire;

  // MULT/MULTU/DIV/DIVU: SPECIAL opcode with fun 0110xx
  assign md_op  = (opcode == 6'd0) && (fun[5:2] == 4'b0110);
  assign bstall = bus_req & waitrequest;

  // Watchdog only observes states that may own the bus
  assign watch   = (state_q == ST_FETCH) || (state_q == ST_EXEC1) || (state_q == ST_EXEC2);
  assign wd_fire = watch && bstall && (stall_cnt_q == STALL_LAST);

  // State and counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
      count_q     <= count_d;
    end
  end

  // Next-state, watchdog and retire logic
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = '0;
    timeout_d   = timeout_q;
    count_d     = count_q;

    if (watch && bstall) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end

    if (wd_fire) begin
      // Timeout outranks every other transition and retires nothing
      state_d     = ST_HALT;
      timeout_d   = 1'b1;
      stall_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_HALT: state_d = ST_HALT;
        ST_FETCH: begin
          if (!bstall) state_d = ST_DECODE;
        end
        ST_DECODE: state_d = ST_EXEC1;
        ST_EXEC1: begin
          if (bstall)               state_d = ST_EXEC1;
          else if (MD_EN && md_op)  state_d = ST_MDWAIT;
          else                      state_d = ST_EXEC2;
        end
        ST_MDWAIT: begin
          if (!md_busy) state_d = ST_EXEC2;
        end
        ST_EXEC2: begin
          // Leaving EXEC2 coincides with the control unit's pcwrite
          if (!bstall) begin
            state_d = halt_req ? ST_HALT : ST_FETCH;
            count_d = count_q + COUNT_W'(1);
          end
        end
        default: state_d = ST_HALT;
      endcase
    end
  end

  assign state       = state_q;
  assign active      = (state_q != ST_HALT);
  assign stalled     = bstall | ((state_q == ST_MDWAIT) & md_busy);
  assign bus_timeout = timeout_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer. dut0: MD_ENABLE=1, MAX_STALL=4, COUNT_W=4.
// dut1: MD_ENABLE=0, MAX_STALL=255, COUNT_W=32, sharing all inputs.
module tb_cpu_sequencer;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  fun;
  logic        bus_req;
  logic        wr;
  logic        md_busy;
  logic        halt_req;
  logic        mem_op;
  logic        ex2_bus;

  logic [3:0]  s0, s1;
  logic        a0, a1, stl0, stl1, to0, to1;
  logic [3:0]  cnt0;
  logic [31:0] cnt1;

  int total;
  int bad;

  // Bus request modelled from dut0's state, as the control unit would decode it
  assign bus_req = (s0 == 4'd1) | ((s0 == 4'd3) & mem_op) | ((s0 == 4'd4) & ex2_bus);

  cpu_sequencer #(.MD_ENABLE(1), .MAX_STALL(4), .COUNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .fun(fun), .bus_req(bus_req),
    .waitrequest(wr), .md_busy(md_busy), .halt_req(halt_req),
    .state(s0), .active(a0), .stalled(stl0), .bus_timeout(to0), .instr_count(cnt0)
  );

  cpu_sequencer #(.MD_ENABLE(0), .MAX_STALL(255), .COUNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .fun(fun), .bus_req(bus_req),
    .waitrequest(wr), .md_busy(md_busy), .halt_req(halt_req),
    .state(s1), .active(a1), .stalled(stl1), .bus_timeout(to1), .instr_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr = 1'b0; md_busy = 1'b0; halt_req = 1'b0; mem_op = 1'b0; ex2_bus = 1'b0;
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr = 1'b0; md_busy = 1'b0; halt_req = 1'b0;
    mem_op = 1'b0; ex2_bus = 1'b0; opcode = 6'd0; fun = 6'd0;
    #2;
    reset = 1'b0;
    #1;
    total++; if (s0 !== 4'd1) begin bad++; $display("FAIL reset_state got=%0d exp=1", s0); end
    total++; if (a0 !== 1'b1) begin bad++; $display("FAIL reset_active got=%0b exp=1", a0); end
    total++; if (to0 !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b exp=0", to0); end
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    total++; if (s1 !== 4'd1) begin bad++; $display("FAIL reset_state1 got=%0d exp=1", s1); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_addiu();
    logic [3:0] exp_s;
    do_reset();
    opcode = 6'b001001; fun = 6'd0;
    for (int c = 1; c <= 12; c++) begin
      halt_req = (c == 12);
      #1;
      exp_s = 4'((c - 1) % 4 + 1);
      total++; if (s0 !== exp_s) begin bad++; $display("FAIL addiu_state c=%0d got=%0d exp=%0d", c, s0, exp_s); end
      total++; if (s1 !== exp_s) begin bad++; $display("FAIL addiu_state1 c=%0d got=%0d exp=%0d", c, s1, exp_s); end
      tick();
    end
    halt_req = 1'b0;
    #1;
    total++; if (s0 !== 4'd0) begin bad++; $display("FAIL addiu_halt got=%0d exp=0", s0); end
    total++; if (a0 !== 1'b0) begin bad++; $display("FAIL addiu_active got=%0b exp=0", a0); end
    total++; if (cnt0 !== 4'd3) begin bad++; $display("FAIL addiu_count got=%0d exp=3", cnt0); end
    total++; if (cnt1 !== 32'd3) begin bad++; $display("FAIL addiu_count1 got=%0d exp=3", cnt1); end
    tick();
    total++; if (s0 !== 4'd0) begin bad++; $display("FAIL addiu_halt_sticky got=%0d exp=0", s0); end
  endtask

  task automatic test_lw();
    logic       wr_v  [9];
    logic [3:0] exp_v [9];
    wr_v  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_v = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    do_reset();
    opcode = 6'b100011; fun = 6'd0; mem_op = 1'b1;
    for (int c = 0; c < 9; c++) begin
      wr = wr_v[c];
      #1;
      total++; if (s0 !== exp_v[c]) begin bad++; $display("FAIL lw_state c=%0d got=%0d exp=%0d", c, s0, exp_v[c]); end
      if (c == 0) begin
        total++; if (stl0 !== 1'b1) begin bad++; $display("FAIL lw_stalled got=%0b exp=1", stl0); end
      end
      if (c == 3) begin
        total++; if (stl0 !== 1'b0) begin bad++; $display("FAIL lw_decode_stalled got=%0b exp=0", stl0); end
      end
      tick();
    end
    wr = 1'b0;
    #1;
    total++; if (s0 !== 4'd1) begin bad++; $display("FAIL lw_end_state got=%0d exp=1", s0); end
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL lw_count got=%0d exp=1", cnt0); end
    mem_op = 1'b0;
  endtask

  task automatic test_mult();
    logic       md_v  [10];
    logic [3:0] e0_v  [10];
    logic [3:0] e1_v  [10];
    logic [3:0] f_v   [5];
    md_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    e0_v = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd4};
    e1_v = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2};
    f_v  = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4};
    do_reset();
    opcode = 6'd0; fun = 6'b011000;
    for (int c = 0; c < 10; c++) begin
      md_busy = md_v[c];
      #1;
      total++; if (s0 !== e0_v[c]) begin bad++; $display("FAIL mult_state c=%0d got=%0d exp=%0d", c, s0, e0_v[c]); end
      total++; if (s1 !== e1_v[c]) begin bad++; $display("FAIL mult_nomd_state c=%0d got=%0d exp=%0d", c, s1, e1_v[c]); end
      if (c == 3) begin
        total++; if (stl0 !== 1'b1) begin bad++; $display("FAIL mult_stalled got=%0b exp=1", stl0); end
      end
      tick();
    end
    md_busy = 1'b0;
    #1;
    total++; if (s0 !== 4'd1) begin bad++; $display("FAIL mult_end_state got=%0d exp=1", s0); end
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL mult_count got=%0d exp=1", cnt0); end
    total++; if (cnt1 !== 32'd2) begin bad++; $display("FAIL mult_nomd_count got=%0d exp=2", cnt1); end
    // md_busy already low: MDWAIT still occupies one cycle
    fun = 6'b011011;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (s0 !== f_v[c]) begin bad++; $display("FAIL mult_fast_state c=%0d got=%0d exp=%0d", c, s0, f_v[c]); end
      if (c == 3) begin
        total++; if (stl0 !== 1'b0) begin bad++; $display("FAIL mult_fast_stalled got=%0b exp=0", stl0); end
      end
      tick();
    end
    #1;
    total++; if (cnt0 !== 4'd2) begin bad++; $display("FAIL mult_fast_count got=%0d exp=2", cnt0); end
  endtask

  task automatic test_watchdog();
    do_reset();
    opcode = 6'b001001; fun = 6'd0;
    for (int c = 0; c < 4; c++) tick();
    #1;
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL wd_pre_count got=%0d exp=1", cnt0); end
    wr = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (s0 !== 4'd1) begin bad++; $display("FAIL wd_stall_state c=%0d got=%0d exp=1", c, s0); end
      total++; if (to0 !== 1'b0) begin bad++; $display("FAIL wd_early_timeout c=%0d got=%0b exp=0", c, to0); end
      tick();
    end
    #1;
    total++; if (s0 !== 4'd0) begin bad++; $display("FAIL wd_halt got=%0d exp=0", s0); end
    total++; if (to0 !== 1'b1) begin bad++; $display("FAIL wd_timeout got=%0b exp=1", to0); end
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL wd_count got=%0d exp=1", cnt0); end
    wr = 1'b0;
    tick();
    #1;
    total++; if (to0 !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%0b exp=1", to0); end
    total++; if (s0 !== 4'd0) begin bad++; $display("FAIL wd_halt_sticky got=%0d exp=0", s0); end
    reset = 1'b0;
    #1;
    total++; if (to0 !== 1'b0) begin bad++; $display("FAIL wd_reset_timeout got=%0b exp=0", to0); end
    total++; if (s0 !== 4'd1) begin bad++; $display("FAIL wd_reset_state got=%0d exp=1", s0); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_no_timeout();
    logic       wr_v  [10];
    logic [3:0] exp_v [10];
    wr_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_v = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    do_reset();
    opcode = 6'b100011; fun = 6'd0; mem_op = 1'b1;
    for (int c = 0; c < 10; c++) begin
      wr = wr_v[c];
      #1;
      total++; if (s0 !== exp_v[c]) begin bad++; $display("FAIL nto_state c=%0d got=%0d exp=%0d", c, s0, exp_v[c]); end
      tick();
    end
    wr = 1'b0;
    #1;
    total++; if (s0 !== 4'd1) begin bad++; $display("FAIL nto_end_state got=%0d exp=1", s0); end
    total++; if (to0 !== 1'b0) begin bad++; $display("FAIL nto_timeout got=%0b exp=0", to0); end
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL nto_count got=%0d exp=1", cnt0); end
    mem_op = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_s;
    do_reset();
    opcode = 6'b001001; fun = 6'd0;
    for (int c = 0; c < 4; c++) tick();
    opcode = 6'd0; fun = 6'b011001; md_busy = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    #1;
    total++; if (s0 !== 4'd5) begin bad++; $display("FAIL mid_md_state got=%0d exp=5", s0); end
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL mid_md_count got=%0d exp=1", cnt0); end
    reset = 1'b0;
    #1;
    total++; if (s0 !== 4'd1) begin bad++; $display("FAIL mid_md_reset_state got=%0d exp=1", s0); end
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL mid_md_reset_count got=%0d exp=0", cnt0); end
    total++; if (stl0 !== 1'b0) begin bad++; $display("FAIL mid_md_reset_stalled got=%0b exp=0", stl0); end
    tick();
    reset = 1'b1; md_busy = 1'b0; opcode = 6'b001001; fun = 6'd0;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_s = 4'(c + 1);
      total++; if (s0 !== exp_s) begin bad++; $display("FAIL mid_md_resume c=%0d got=%0d exp=%0d", c, s0, exp_s); end
      tick();
    end
    #1;
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL mid_md_resume_count got=%0d exp=1", cnt0); end
    // Stall in EXEC2 with halt_req pending: stall must win
    ex2_bus = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    wr = 1'b1; halt_req = 1'b1;
    #1;
    total++; if (s0 !== 4'd4) begin bad++; $display("FAIL mid_ex2_state got=%0d exp=4", s0); end
    total++; if (stl0 !== 1'b1) begin bad++; $display("FAIL mid_ex2_stalled got=%0b exp=1", stl0); end
    tick();
    #1;
    total++; if (s0 !== 4'd4) begin bad++; $display("FAIL mid_ex2_hold got=%0d exp=4", s0); end
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL mid_ex2_count got=%0d exp=1", cnt0); end
    reset = 1'b0;
    #1;
    total++; if (s0 !== 4'd1) begin bad++; $display("FAIL mid_ex2_reset_state got=%0d exp=1", s0); end
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL mid_ex2_reset_count got=%0d exp=0", cnt0); end
    tick();
    reset = 1'b1; wr = 1'b0; halt_req = 1'b0; ex2_bus = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_s = 4'(c + 1);
      total++; if (s0 !== exp_s) begin bad++; $display("FAIL mid_ex2_resume c=%0d got=%0d exp=%0d", c, s0, exp_s); end
      tick();
    end
    #1;
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL mid_ex2_resume_count got=%0d exp=1", cnt0); end
  endtask

  task automatic test_wrap();
    do_reset();
    opcode = 6'b001001; fun = 6'd0;
    for (int i = 1; i <= 68; i++) begin
      tick();
      if (i == 60) begin
        total++; if (cnt0 !== 4'd15) begin bad++; $display("FAIL wrap_15 got=%0d exp=15", cnt0); end
      end
      if (i == 64) begin
        total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL wrap_0 got=%0d exp=0", cnt0); end
      end
      if (i == 68) begin
        total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL wrap_1 got=%0d exp=1", cnt0); end
        total++; if (cnt1 !== 32'd17) begin bad++; $display("FAIL wrap_wide got=%0d exp=17", cnt1); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_addiu();
    test_lw();
    test_mult();
    test_watchdog();
    test_no_timeout();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
